mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the request address width.
REQ-002 Parameter DDATA_W, default 32, SHALL set the data width.
REQ-003 Parameter DEPTH_LOG2, default 10, SHALL set the word storage depth (2^DEPTH_LOG2 words).
REQ-004 Parameter LATENCY, default 2, range 1..15, SHALL set the busy cycles per access.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 memReq  input  1  request strobe from the initiator, sampled only in IDLE.
REQ-008 memAddr  input  ADDR_W  byte address of the request.
REQ-009 memWr  input  1  1 = store, 0 = load.
REQ-010 memDataOut  input  DDATA_W  store data from the initiator.
REQ-011 memBusyIn  output  1  responder busy; the initiator holds off new requests while high.
REQ-012 memDataIn  output  DDATA_W  load data returned to the initiator.
REQ-013 memValid  output  1  one-cycle pulse marking completion of an access.
REQ-014 memErr  output  1  one-cycle pulse, coincident with memValid, marking a faulted access.

Function
REQ-015 The block SHALL implement the states IDLE and BUSY.
REQ-016 IDLE to BUSY transition:
- Trigger: memReq=1 at a rising edge while in IDLE.
- The block SHALL latch memAddr, memWr and memDataOut.
- It SHALL load the wait counter with LATENCY-1.
- It SHALL set memBusyIn to 1.
REQ-017 In BUSY with counter != 0, the block SHALL decrement the counter at each edge. Input changes SHALL NOT affect the latched request.
REQ-018 In BUSY with counter == 0, at the next edge the block SHALL:
- perform the access;
- set memBusyIn to 0;
- set memValid to 1;
- return to IDLE.
REQ-019 memBusyIn SHALL be high for exactly LATENCY cycles per access. memValid SHALL rise LATENCY+1 cycles after the accepting edge.
REQ-020 memValid and memErr SHALL clear at the edge after they are set.
REQ-021 Word index SHALL be memAddr[DEPTH_LOG2+1:2].
REQ-022 An access SHALL fault when either condition holds:
- memAddr[1:0] != 0;
- any memAddr bit above DEPTH_LOG2+1 is 1.
REQ-023 A faulted store SHALL NOT modify storage. A faulted load SHALL return memDataIn=0. Both SHALL pulse memErr with memValid.
REQ-024 A good store SHALL write the latched data at the completion edge and leave memDataIn unchanged.
REQ-025 A good load SHALL drive the stored word on memDataIn at the completion edge. memDataIn SHALL hold that value until the next load completes.
REQ-026 memReq during BUSY, or during the memValid cycle, SHALL be ignored.
REQ-027 A request SHALL be accepted the edge after memValid rises if memReq is high and the state is IDLE.
REQ-028 Back-to-back requests SHALL therefore complete every LATENCY+1 cycles.
REQ-029 A load immediately following a store to the same address SHALL return the newly stored data.

Reset
REQ-030 With reset=0 the block SHALL asynchronously force:
- state IDLE;
- counter 0;
- memBusyIn=0, memValid=0, memErr=0;
- memDataIn=0.
REQ-031 Reset asserted mid-access SHALL abort the access with no storage write and no memValid pulse.
REQ-032 Storage contents SHALL NOT be cleared by reset.
REQ-033 The first request SHALL be accepted at the first edge after reset deasserts.

Verification
REQ-034 LATENCY=2; store 0xDEADBEEF to 0x10, then load 0x10 -> each access: busy for 2 cycles, memValid at cycle 3; load returns 0xDEADBEEF, memErr=0.
REQ-035 Load from 0x13 (misaligned) -> memValid and memErr pulse together, memDataIn=0; a following load from 0x10 still returns 0xDEADBEEF.
REQ-036 DEPTH_LOG2=10; store 0x1 to 0x1000 (out of range) -> memErr=1; a load from 0x0 returns its prior value, unchanged.
REQ-037 memReq held high continuously over 3 requests -> exactly 3 memValid pulses, spaced LATENCY+1 cycles apart; no request accepted while busy.
REQ-038 Store 0x55 to 0x20, with reset pulsed low during the first busy cycle -> all outputs 0 immediately, no memValid pulse; a later load from 0x20 returns the pre-reset contents, not 0x55.
REQ-039 LATENCY=1 boundary -> busy high for 1 cycle, memValid on the 2nd cycle after acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory responder with alignment/range fault reporting
module mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DDATA_W    = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memReq,
    input  logic [ADDR_W-1:0]  memAddr,
    input  logic               memWr,
    input  logic [DDATA_W-1:0] memDataOut,
    output logic               memBusyIn,
    output logic [DDATA_W-1:0] memDataIn,
    output logic               memValid,
    output logic               memErr
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    // LATENCY is limited to 1..15, so the wait counter fits in four bits.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic [DDATA_W-1:0]   wdata_q, wdata_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [DDATA_W-1:0]   rdata_q, rdata_d;

    // Word storage: deliberately has no reset so contents survive a reset pulse.
    logic [DDATA_W-1:0]   mem [DEPTH];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  fault;
    logic                  complete;
    logic                  mem_we;

    assign word_idx = addr_q[DEPTH_LOG2+1:2];
    assign complete = (state_q == BUSY) && (cnt_q == 4'd0);
    // A store only lands on a clean completion; reset forces IDLE, so an
    // aborted access can never reach this point.
    assign mem_we   = reset && complete && wr_q && !fault;

    // Fault when the byte address is not word aligned or lies beyond the storage.
    always_comb begin
        fault = 1'b0;
        if (addr_q[1:0] != 2'b00) begin
            fault = 1'b1;
        end
        if ((addr_q >> (DEPTH_LOG2 + 2)) != '0) begin
            fault = 1'b1;
        end
    end

    // Next-state and next-output computation for the IDLE/BUSY handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (memReq) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    addr_d  = memAddr;
                    wr_d    = memWr;
                    wdata_d = memDataOut;
                    busy_d  = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    err_d   = fault;
                    // Stores leave the returned data untouched; loads update it.
                    if (!wr_q) begin
                        rdata_d = fault ? '0 : mem[word_idx];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control, latched request and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage write at the completion edge of a good store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= wdata_q;
        end
    end

    assign memBusyIn = busy_q;
    assign memValid  = valid_q;
    assign memErr    = err_q;
    assign memDataIn = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder at LATENCY 2 and 1
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;

    logic        busy_a, valid_a, err_a;
    logic [31:0] rd_a;
    logic        busy_b, valid_b, err_b;
    logic [31:0] rd_b;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(32), .DDATA_W(32), .DEPTH_LOG2(10), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .memReq(req), .memAddr(addr), .memWr(wr),
        .memDataOut(wdata), .memBusyIn(busy_a), .memDataIn(rd_a),
        .memValid(valid_a), .memErr(err_a)
    );

    mem_responder #(.ADDR_W(32), .DDATA_W(32), .DEPTH_LOG2(10), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .memReq(req), .memAddr(addr), .memWr(wr),
        .memDataOut(wdata), .memBusyIn(busy_b), .memDataIn(rd_b),
        .memValid(valid_b), .memErr(err_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: word array plus the last value a load returned.
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_rd;
    logic [31:0] e_rd;
    logic        e_err;

    // Per-access observations for both instances.
    int          m_busy_a, m_vcyc_a, m_vn_a, m_en_a;
    logic [31:0] m_rd_a;
    logic        m_err_a;
    int          m_busy_b, m_vcyc_b, m_vn_b, m_en_b;
    logic [31:0] m_rd_b;
    logic        m_err_b;

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    task automatic model_access(input logic [31:0] a, input logic w, input logic [31:0] d);
        e_err = is_fault(a);
        if (!e_err) begin
            if (w) ref_mem[a / 4] = d;
            else   ref_rd = ref_mem[a / 4];
        end else if (!w) begin
            ref_rd = 32'd0;
        end
        e_rd = ref_rd;
    endtask

    task automatic measure();
        m_busy_a = 0; m_vcyc_a = 0; m_vn_a = 0; m_en_a = 0; m_rd_a = 'x; m_err_a = 1'bx;
        m_busy_b = 0; m_vcyc_b = 0; m_vn_b = 0; m_en_b = 0; m_rd_b = 'x; m_err_b = 1'bx;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy_a) m_busy_a++;
            if (err_a)  m_en_a++;
            if (valid_a) begin
                m_vn_a++;
                if (m_vn_a == 1) begin m_vcyc_a = i; m_rd_a = rd_a; m_err_a = err_a; end
            end
            if (busy_b) m_busy_b++;
            if (err_b)  m_en_b++;
            if (valid_b) begin
                m_vn_b++;
                if (m_vn_b == 1) begin m_vcyc_b = i; m_rd_b = rd_b; m_err_b = err_b; end
            end
        end
    endtask

    // Caller is at a negedge; the next posedge is the accepting edge.
    task automatic launch(input logic [31:0] a, input logic w, input logic [31:0] d);
        req = 1'b1; addr = a; wr = w; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; addr = $urandom; wr = 1'($urandom); wdata = $urandom;
        measure();
    endtask

    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(negedge clk);
        launch(a, w, d);
        model_access(a, w, d);
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b0; addr = '0; wr = 1'b0; wdata = '0;
        ref_rd = 32'd0;
        #1;
        total++;
        if ({busy_a, valid_a, err_a, rd_a} !== 35'd0) begin
            bad++; $display("FAIL reset_a: got busy=%b valid=%b err=%b data=%h want all 0", busy_a, valid_a, err_a, rd_a);
        end
        total++;
        if ({busy_b, valid_b, err_b, rd_b} !== 35'd0) begin
            bad++; $display("FAIL reset_b: got busy=%b valid=%b err=%b data=%h want all 0", busy_b, valid_b, err_b, rd_b);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_store_load();
        access(32'h10, 1'b1, 32'hDEADBEEF);
        total++;
        if (m_busy_a !== 2 || m_vcyc_a !== 3 || m_vn_a !== 1) begin
            bad++; $display("FAIL store_timing_a: busy=%0d vcyc=%0d pulses=%0d want 2 3 1", m_busy_a, m_vcyc_a, m_vn_a);
        end
        total++;
        if (m_busy_b !== 1 || m_vcyc_b !== 2 || m_vn_b !== 1) begin
            bad++; $display("FAIL store_timing_b: busy=%0d vcyc=%0d pulses=%0d want 1 2 1", m_busy_b, m_vcyc_b, m_vn_b);
        end
        total++;
        if (m_err_a !== 1'b0 || m_rd_a !== e_rd) begin
            bad++; $display("FAIL store_result_a: err=%b data=%h want 0 %h", m_err_a, m_rd_a, e_rd);
        end
        access(32'h10, 1'b0, 32'h0);
        total++;
        if (m_rd_a !== 32'hDEADBEEF || m_err_a !== 1'b0 || m_vcyc_a !== 3) begin
            bad++; $display("FAIL load_a: data=%h err=%b vcyc=%0d want deadbeef 0 3", m_rd_a, m_err_a, m_vcyc_a);
        end
        total++;
        if (m_rd_b !== 32'hDEADBEEF || m_err_b !== 1'b0) begin
            bad++; $display("FAIL load_b: data=%h err=%b want deadbeef 0", m_rd_b, m_err_b);
        end
    endtask

    task automatic test_misaligned();
        access(32'h13, 1'b0, 32'h0);
        total++;
        if (m_err_a !== 1'b1 || m_rd_a !== 32'd0 || m_vn_a !== 1 || m_en_a !== 1) begin
            bad++; $display("FAIL misaligned_a: err=%b data=%h pulses=%0d errpulses=%0d want 1 0 1 1", m_err_a, m_rd_a, m_vn_a, m_en_a);
        end
        total++;
        if (m_err_b !== 1'b1 || m_rd_b !== 32'd0) begin
            bad++; $display("FAIL misaligned_b: err=%b data=%h want 1 0", m_err_b, m_rd_b);
        end
        access(32'h10, 1'b0, 32'h0);
        total++;
        if (m_rd_a !== 32'hDEADBEEF || m_err_a !== 1'b0) begin
            bad++; $display("FAIL after_misaligned: data=%h err=%b want deadbeef 0", m_rd_a, m_err_a);
        end
    endtask

    task automatic test_out_of_range();
        access(32'h0, 1'b1, 32'h11111111);
        access(32'h1000, 1'b1, 32'h1);
        total++;
        if (m_err_a !== 1'b1 || m_err_b !== 1'b1 || m_vn_a !== 1) begin
            bad++; $display("FAIL oor_store: err_a=%b err_b=%b pulses=%0d want 1 1 1", m_err_a, m_err_b, m_vn_a);
        end
        access(32'h0, 1'b0, 32'h0);
        total++;
        if (m_rd_a !== 32'h11111111 || m_rd_b !== 32'h11111111) begin
            bad++; $display("FAIL oor_untouched: data_a=%h data_b=%h want 11111111", m_rd_a, m_rd_b);
        end
    endtask

    task automatic test_back_to_back();
        int exp_a[$];
        int exp_b[$];
        int got_a[$];
        int got_b[$];
        int busy_cnt_a;
        // Requests held through edge 6: accepted at multiples of L+1, completing L+1 later.
        for (int t = 0; t <= 6; t += 3) exp_a.push_back(t + 3);
        for (int t = 0; t <= 6; t += 2) exp_b.push_back(t + 2);
        busy_cnt_a = 0;
        @(negedge clk);
        req = 1'b1; addr = 32'h10; wr = 1'b0; wdata = 32'h0;
        @(posedge clk);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (busy_a) busy_cnt_a++;
            if (valid_a) begin
                got_a.push_back(i);
                total++;
                if (rd_a !== 32'hDEADBEEF) begin
                    bad++; $display("FAIL b2b_data_a: cycle=%0d data=%h want deadbeef", i, rd_a);
                end
            end
            if (valid_b) got_b.push_back(i);
            if (i == 7) req = 1'b0;
        end
        total++;
        if (got_a != exp_a) begin
            bad++; $display("FAIL b2b_pulses_a: got %p want %p", got_a, exp_a);
        end
        total++;
        if (got_b != exp_b) begin
            bad++; $display("FAIL b2b_pulses_b: got %p want %p", got_b, exp_b);
        end
        total++;
        if (busy_cnt_a != 6) begin
            bad++; $display("FAIL b2b_busy_a: got %0d want 6", busy_cnt_a);
        end
        ref_rd = 32'hDEADBEEF;
    endtask

    task automatic test_reset_abort();
        int vn;
        access(32'h20, 1'b1, 32'hAAAA0000);
        @(negedge clk);
        req = 1'b1; addr = 32'h20; wr = 1'b1; wdata = 32'h55;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({busy_a, valid_a, err_a, rd_a} !== 35'd0 || {busy_b, valid_b, err_b, rd_b} !== 35'd0) begin
            bad++; $display("FAIL abort_outputs: a=%b%b%b %h b=%b%b%b %h want all 0",
                            busy_a, valid_a, err_a, rd_a, busy_b, valid_b, err_b, rd_b);
        end
        vn = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (valid_a || valid_b) vn++;
        end
        reset = 1'b1;
        ref_rd = 32'd0;
        launch(32'h20, 1'b0, 32'h0);
        model_access(32'h20, 1'b0, 32'h0);
        vn += (m_vn_a - 1);
        total++;
        if (vn !== 0) begin
            bad++; $display("FAIL abort_no_valid: extra pulses=%0d want 0", vn);
        end
        total++;
        if (m_vcyc_a !== 3 || m_vcyc_b !== 2) begin
            bad++; $display("FAIL first_accept: vcyc_a=%0d vcyc_b=%0d want 3 2", m_vcyc_a, m_vcyc_b);
        end
        total++;
        if (m_rd_a !== 32'hAAAA0000 || m_rd_b !== 32'hAAAA0000) begin
            bad++; $display("FAIL abort_storage: data_a=%h data_b=%h want aaaa0000", m_rd_a, m_rd_b);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        int          kind;
        for (int i = 0; i < 16; i++) access(32'(i * 4), 1'b1, $urandom);
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            a = 32'($urandom_range(0, 15) * 4);
            if (kind == 0)      a = a | 32'($urandom_range(1, 3));
            else if (kind == 1) a = a | (32'($urandom_range(1, 20'hFFFFF)) << 12);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            access(a, w, d);
            total++;
            if (m_vn_a !== 1 || m_vcyc_a !== 3 || m_busy_a !== 2) begin
                bad++; $display("FAIL rnd_timing_a: op=%0d pulses=%0d vcyc=%0d busy=%0d want 1 3 2", n, m_vn_a, m_vcyc_a, m_busy_a);
            end
            total++;
            if (m_err_a !== e_err || m_en_a !== int'(e_err) || m_rd_a !== e_rd) begin
                bad++; $display("FAIL rnd_result_a: op=%0d addr=%h wr=%b err=%b errpulses=%0d data=%h want err=%b data=%h",
                                n, a, w, m_err_a, m_en_a, m_rd_a, e_err, e_rd);
            end
            total++;
            if (rd_a !== e_rd) begin
                bad++; $display("FAIL rnd_hold_a: op=%0d data=%h want %h", n, rd_a, e_rd);
            end
            total++;
            if (m_vcyc_b !== 2 || m_err_b !== e_err || m_rd_b !== e_rd) begin
                bad++; $display("FAIL rnd_result_b: op=%0d vcyc=%0d err=%b data=%h want 2 %b %h", n, m_vcyc_b, m_err_b, m_rd_b, e_err, e_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
